// File: rtl/regex_cpu_pipelined.sv
// Pipelined regex thread processor: fetch -> execute -> output FIFO.
// One thread is fetched at a time. Execute spawns up to two threads per instruction.
module regex_cpu_pipelined #(
  parameter int PC_WIDTH              = 9,
  parameter int CHARACTER_WIDTH       = 8,
  parameter int MEMORY_WIDTH          = 16,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2,
  parameter int CC_ID_BITS            = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]   current_characters,
  input  logic [(2**CC_ID_BITS)-1:0]                   end_of_string,
  input  logic                                         input_pc_valid,
  output logic                                         input_pc_ready,
  input  logic [PC_WIDTH-1:0]                          input_pc,
  input  logic [CC_ID_BITS-1:0]                        input_cc_id,
  output logic                                         memory_valid,
  input  logic                                         memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                 memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                      memory_data,
  output logic                                         output_pc_valid,
  input  logic                                         output_pc_ready,
  output logic [PC_WIDTH-1:0]                          output_pc,
  output logic [CC_ID_BITS-1:0]                        output_cc_id,
  output logic                                         accepts,
  output logic [(2**CC_ID_BITS)-1:0]                   elaborating_chars,
  output logic                                         running
);
  localparam int DEPTH = 2**FIFO_WIDTH_POWER_OF_2;
  localparam int PTR_W = FIFO_WIDTH_POWER_OF_2;
  localparam int CNT_W = FIFO_WIDTH_POWER_OF_2 + 1;

  localparam logic [2:0] OP_ACCEPT         = 3'b000;
  localparam logic [2:0] OP_SPLIT          = 3'b001;
  localparam logic [2:0] OP_MATCH          = 3'b010;
  localparam logic [2:0] OP_JMP            = 3'b011;
  localparam logic [2:0] OP_MATCH_ANY      = 3'b101;
  localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'b110;
  localparam logic [2:0] OP_NOT_MATCH      = 3'b111;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD} fetch_state_t;

  fetch_state_t              fetch_state_reg, fetch_state_next;
  logic [PC_WIDTH-1:0]       fetch_pc_reg;
  logic [CC_ID_BITS-1:0]     fetch_cc_reg;
  logic [MEMORY_WIDTH-1:0]   fetch_instr_reg;

  logic                      exec_valid_reg;
  logic [PC_WIDTH-1:0]       exec_pc_reg;
  logic [CC_ID_BITS-1:0]     exec_cc_reg;
  logic [MEMORY_WIDTH-1:0]   exec_instr_reg;
  logic                      exec_load, exec_fire;

  logic [PC_WIDTH-1:0]       fifo_pc_mem  [DEPTH];
  logic [CC_ID_BITS-1:0]     fifo_cc_mem  [DEPTH];
  logic [CC_ID_BITS-1:0]     fifo_org_mem [DEPTH];
  logic [PTR_W-1:0]          fifo_rd_ptr_reg, fifo_wr_ptr_reg, fifo_wr_ptr_inc;
  logic [CNT_W-1:0]          fifo_count_reg, fifo_space;
  logic [DEPTH-1:0]          slot_busy;
  logic                      pop;
  logic                      accepts_reg;

  // ---------------- fetch ----------------
  always_comb begin
    fetch_state_next = fetch_state_reg;
    case (fetch_state_reg)
      F_IDLE:  if (input_pc_valid) fetch_state_next = F_REQ;
      F_REQ:   if (memory_ready) fetch_state_next = F_WAIT;
      F_WAIT:  fetch_state_next = F_HOLD;
      F_HOLD:  if (exec_load) fetch_state_next = F_IDLE;
      default: fetch_state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_state_reg <= F_IDLE;
      fetch_pc_reg    <= '0;
      fetch_cc_reg    <= '0;
      fetch_instr_reg <= '0;
    end else begin
      fetch_state_reg <= fetch_state_next;
      if (fetch_state_reg == F_IDLE && input_pc_valid) begin
        fetch_pc_reg <= input_pc;
        fetch_cc_reg <= input_cc_id;
      end
      // Memory data is only valid for the single cycle after the request handshake.
      if (fetch_state_reg == F_WAIT) fetch_instr_reg <= memory_data;
    end
  end

  assign input_pc_ready = (fetch_state_reg == F_IDLE);
  assign memory_valid   = (fetch_state_reg == F_REQ);
  assign memory_addr    = MEMORY_ADDR_WIDTH'(fetch_pc_reg);
  assign exec_load      = (fetch_state_reg == F_HOLD) && (!exec_valid_reg || exec_fire);

  // ---------------- execute ----------------
  logic [2:0]                 opcode;
  logic [CHARACTER_WIDTH-1:0] exec_char;
  logic                       exec_eos;
  logic [PC_WIDTH-1:0]        pc_inc, target;
  logic [CC_ID_BITS-1:0]      cc_inc;
  logic [CNT_W-1:0]           push_n, push_eff;
  logic [PC_WIDTH-1:0]        push0_pc, push1_pc;
  logic [CC_ID_BITS-1:0]      push0_cc, push1_cc;
  logic                       accept_hit;
  logic                       unused_instr_bits;

  assign opcode            = exec_instr_reg[MEMORY_WIDTH-1 -: 3];
  assign exec_char         = current_characters[exec_cc_reg*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign exec_eos          = end_of_string[exec_cc_reg];
  assign pc_inc            = exec_pc_reg + 1'b1;
  assign cc_inc            = exec_cc_reg + 1'b1;
  assign target            = exec_instr_reg[PC_WIDTH-1:0];
  assign unused_instr_bits = ^exec_instr_reg;

  always_comb begin
    push_n     = '0;
    push0_pc   = pc_inc;
    push0_cc   = exec_cc_reg;
    push1_pc   = target;
    push1_cc   = exec_cc_reg;
    accept_hit = 1'b0;
    case (opcode)
      OP_SPLIT: push_n = CNT_W'(2);
      OP_JMP: begin
        push_n   = CNT_W'(1);
        push0_pc = target;
      end
      OP_MATCH: if (exec_char == exec_instr_reg[CHARACTER_WIDTH-1:0] && !exec_eos) begin
        push_n   = CNT_W'(1);
        push0_cc = cc_inc;
      end
      OP_NOT_MATCH: if (exec_char != exec_instr_reg[CHARACTER_WIDTH-1:0] && !exec_eos) begin
        push_n   = CNT_W'(1);
        push0_cc = cc_inc;
      end
      OP_MATCH_ANY: if (!exec_eos) begin
        push_n   = CNT_W'(1);
        push0_cc = cc_inc;
      end
      OP_ACCEPT:         accept_hit = exec_eos;
      OP_ACCEPT_PARTIAL: accept_hit = 1'b1;
      default: ;
    endcase
  end

  // The instruction retires only when every thread it spawns fits in the FIFO.
  assign fifo_space = CNT_W'(DEPTH) - fifo_count_reg;
  assign exec_fire  = exec_valid_reg && (fifo_space >= push_n);
  assign push_eff   = exec_fire ? push_n : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_valid_reg <= 1'b0;
      exec_pc_reg    <= '0;
      exec_cc_reg    <= '0;
      exec_instr_reg <= '0;
      accepts_reg    <= 1'b0;
    end else begin
      if (exec_load) begin
        exec_valid_reg <= 1'b1;
        exec_pc_reg    <= fetch_pc_reg;
        exec_cc_reg    <= fetch_cc_reg;
        exec_instr_reg <= fetch_instr_reg;
      end else if (exec_fire) begin
        exec_valid_reg <= 1'b0;
      end
      accepts_reg <= exec_fire && accept_hit;
    end
  end

  // ---------------- output FIFO ----------------
  assign fifo_wr_ptr_inc = fifo_wr_ptr_reg + 1'b1;
  assign output_pc_valid = (fifo_count_reg != '0);
  assign pop             = output_pc_valid && output_pc_ready;

  always_ff @(posedge clk) begin
    if (exec_fire && push_n != '0) begin
      fifo_pc_mem[fifo_wr_ptr_reg]  <= push0_pc;
      fifo_cc_mem[fifo_wr_ptr_reg]  <= push0_cc;
      fifo_org_mem[fifo_wr_ptr_reg] <= exec_cc_reg;
    end
    if (exec_fire && push_n == CNT_W'(2)) begin
      fifo_pc_mem[fifo_wr_ptr_inc]  <= push1_pc;
      fifo_cc_mem[fifo_wr_ptr_inc]  <= push1_cc;
      fifo_org_mem[fifo_wr_ptr_inc] <= exec_cc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_ptr_reg <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_count_reg  <= '0;
    end else begin
      fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PTR_W'(push_eff);
      fifo_rd_ptr_reg <= fifo_rd_ptr_reg + PTR_W'(pop);
      fifo_count_reg  <= fifo_count_reg + push_eff - CNT_W'(pop);
    end
  end

  assign output_pc    = output_pc_valid ? fifo_pc_mem[fifo_rd_ptr_reg] : '0;
  assign output_cc_id = output_pc_valid ? fifo_cc_mem[fifo_rd_ptr_reg] : '0;
  assign accepts      = accepts_reg;

  // ---------------- status ----------------
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] slot_age;
    assign slot_age      = PTR_W'(gi) - fifo_rd_ptr_reg;
    assign slot_busy[gi] = CNT_W'(slot_age) < fifo_count_reg;
  end

  // FIFO entries remember the context of the thread that spawned them.
  always_comb begin
    elaborating_chars = '0;
    if (fetch_state_reg != F_IDLE) elaborating_chars[fetch_cc_reg] = 1'b1;
    if (exec_valid_reg) elaborating_chars[exec_cc_reg] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_busy[i]) elaborating_chars[fifo_org_mem[i]] = 1'b1;
    end
  end

  assign running = (fetch_state_reg != F_IDLE) || exec_valid_reg || output_pc_valid;

endmodule

// File: tb/tb_regex_cpu_pipelined.sv
// Randomized scoreboard bench for regex_cpu_pipelined with a memory model and
// a behavioural reference model of the instruction set.
module tb_regex_cpu_pipelined;
  localparam int PCW = 9, CW = 8, MW = 16, MAW = 11, FP = 2, CCB = 2, N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*CW-1:0]  current_characters;
  logic [N-1:0]     end_of_string;
  logic             input_pc_valid, input_pc_ready;
  logic [PCW-1:0]   input_pc;
  logic [CCB-1:0]   input_cc_id;
  logic             memory_valid, memory_ready;
  logic [MAW-1:0]   memory_addr;
  logic [MW-1:0]    memory_data;
  logic             output_pc_valid, output_pc_ready;
  logic [PCW-1:0]   output_pc;
  logic [CCB-1:0]   output_cc_id;
  logic             accepts;
  logic [N-1:0]     elaborating_chars;
  logic             running;

  regex_cpu_pipelined #(
    .PC_WIDTH(PCW), .CHARACTER_WIDTH(CW), .MEMORY_WIDTH(MW),
    .MEMORY_ADDR_WIDTH(MAW), .FIFO_WIDTH_POWER_OF_2(FP), .CC_ID_BITS(CCB)
  ) dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
    .input_pc(input_pc), .input_cc_id(input_cc_id),
    .memory_valid(memory_valid), .memory_ready(memory_ready),
    .memory_addr(memory_addr), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
    .output_pc(output_pc), .output_cc_id(output_cc_id),
    .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [15:0] prog [0:511];
  int          exp_q[$];
  int          exp_acc = 0, acc_seen = 0, pops = 0;
  bit          stall = 1'b0;
  int          mem_pct = 100, out_pct = 100;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference model: expected spawned threads / accept pulses of one thread.
  task automatic model(int pc, int cc);
    logic [15:0] ins;
    int op, d, ch, e, npc, ncc, tgt;
    ins = prog[pc];
    op  = int'(ins[15:13]);
    d   = int'(ins[12:0]);
    ch  = int'((current_characters >> (8 * cc)) & 32'hff);
    e   = int'((end_of_string >> cc) & 4'h1);
    npc = (pc + 1) % 512;
    ncc = (cc + 1) % 4;
    tgt = d % 512;
    case (op)
      0: if (e == 1) exp_acc++;
      1: begin exp_q.push_back(npc * 16 + cc); exp_q.push_back(tgt * 16 + cc); end
      2: if (ch == d % 256 && e == 0) exp_q.push_back(npc * 16 + ncc);
      3: exp_q.push_back(tgt * 16 + cc);
      5: if (e == 0) exp_q.push_back(npc * 16 + ncc);
      6: exp_acc++;
      7: if (ch != d % 256 && e == 0) exp_q.push_back(npc * 16 + ncc);
      default: ;
    endcase
  endtask

  // Memory: data valid only in the cycle after the handshake, garbage otherwise.
  initial begin
    logic       hs;
    logic [10:0] a;
    memory_ready = 1'b0;
    memory_data  = '0;
    forever begin
      @(negedge clk);
      hs = memory_valid && memory_ready;
      a  = memory_addr;
      @(posedge clk); #1;
      memory_data  = hs ? prog[a[8:0]] : 16'($urandom);
      memory_ready = ($urandom_range(0, 99) < mem_pct);
    end
  end

  initial begin
    output_pc_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      output_pc_ready = !stall && ($urandom_range(0, 99) < out_pct);
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit hold;
    int prev_key, key, idx;
    hold = 0; prev_key = 0;
    forever begin
      @(negedge clk);
      if (rst) begin hold = 0; continue; end
      key = int'(output_pc) * 16 + int'(output_cc_id);
      if (accepts) acc_seen++;
      if (hold) begin
        chk("hold_valid", output_pc_valid, 1);
        if (output_pc_valid) chk("hold_data", key, prev_key);
      end
      if (output_pc_valid && output_pc_ready) begin
        pops++;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i] == key) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL out_unexpected: got pc=%0d cc=%0d, required one of %0d pending",
                   output_pc, output_cc_id, exp_q.size());
        end else begin
          exp_q.delete(idx);
        end
      end
      hold = output_pc_valid && !output_pc_ready;
      prev_key = key;
    end
  end

  task automatic issue(int pc, int cc);
    model(pc, cc);
    input_pc = PCW'(pc); input_cc_id = CCB'(cc); input_pc_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (input_pc_ready) break;
      if (t > 300) begin chk("issue_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    input_pc_valid = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (!running) break;
      if (t > 2000) begin chk({tag, "_idle_timeout"}, 0, 1); break; end
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_lost"}, exp_q.size(), 0);
    chk({tag, "_accepts"}, acc_seen, exp_acc);
    exp_q.delete(); acc_seen = 0; exp_acc = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_in_ready"}, input_pc_ready, 1);
    chk({tag, "_mem_valid"}, memory_valid, 0);
    chk({tag, "_out_valid"}, output_pc_valid, 0);
    chk({tag, "_accepts"}, accepts, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_elab"}, elaborating_chars, 0);
    chk({tag, "_mem_addr"}, memory_addr, 0);
    chk({tag, "_out_pc"}, output_pc, 0);
    chk({tag, "_out_cc"}, output_cc_id, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1;
    input_pc_valid = 1'b0; input_pc = '0; input_cc_id = '0;
    current_characters = '0; end_of_string = '0;
    for (int i = 0; i < 512; i++) prog[i] = {3'b100, 13'd0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle: nothing happens spontaneously.
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("idle_running", running, 0);
      chk("idle_out_valid", output_pc_valid, 0);
      chk("idle_mem_valid", memory_valid, 0);
    end

    // Directed SPLIT at pc 245, context 2.
    prog[245] = {3'b001, 13'd0};
    model(245, 2);
    input_pc = 9'd245; input_cc_id = 2'd2; input_pc_valid = 1'b1;
    @(negedge clk);
    chk("d_in_ready", input_pc_ready, 1);
    @(posedge clk); #1;
    input_pc_valid = 1'b0;
    chk("d_mem_valid_req", memory_valid, 1);
    chk("d_mem_addr", memory_addr, 245);
    @(posedge clk); #1;
    chk("d_mem_valid_wait", memory_valid, 0);
    @(posedge clk); #1;
    chk("d_mem_valid_sampled", memory_valid, 0);
    chk("d_elab2", elaborating_chars[2], 1);
    chk("d_running", running, 1);
    wait_idle("d_split");
    chk("d_running_after", running, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("d_post_idle_out", output_pc_valid, 0);
    end

    // SPLIT sweep: pc 245..269 x all contexts, then target sweep at pc 511.
    mem_pct = 70; out_pct = 70;
    for (int pc = 245; pc <= 269; pc++) begin
      prog[pc] = {3'b001, 13'($urandom_range(0, 63))};
      for (int cc = 0; cc < 4; cc++) issue(pc, cc);
      wait_idle("sweep");
    end
    for (int t = 0; t < 64; t++) begin
      prog[511] = {3'b001, 13'(t)};
      issue(511, t % 4);
      wait_idle("wrap");
    end

    // Output back-pressure for 20 cycles.
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    prog[300] = {3'b001, 13'd17};
    issue(300, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_valid", output_pc_valid, 1);
    chk("stall_pc_ok", (output_pc == 9'd301 || output_pc == 9'd17), 1);
    stall = 1'b0;
    wait_idle("stall");

    // MATCH hit / miss, ACCEPT with end of string.
    current_characters = 32'h0000_4100; end_of_string = 4'b0000;
    prog[100] = {3'b010, 13'h041};
    p0 = pops;
    issue(100, 1);
    wait_idle("match_hit");
    chk("match_hit_pops", pops - p0, 1);
    current_characters = 32'h0000_4200;
    p0 = pops;
    issue(100, 1);
    wait_idle("match_miss");
    chk("match_miss_pops", pops - p0, 0);
    end_of_string = 4'b1000;
    prog[120] = {3'b000, 13'd0};
    issue(120, 3);
    wait_idle("accept_eos");

    // Randomized batches over a random program.
    mem_pct = 60; out_pct = 60;
    for (int i = 0; i < 512; i++)
      prog[i] = {3'($urandom), 5'($urandom), 8'(8'h41 + $urandom_range(0, 2))};
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < N; k++)
        current_characters[k*CW +: CW] = 8'(8'h41 + $urandom_range(0, 2));
      end_of_string = 4'($urandom);
      for (int t = 0; t < 15; t++) issue($urandom_range(0, 511), $urandom_range(0, 3));
      wait_idle("random");
    end

    // Reset in the middle of a fetch discards the thread.
    prog[50] = {3'b001, 13'd7};
    issue(50, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete(); exp_acc = 0; acc_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("midrst_idle_out", output_pc_valid, 0);
      chk("midrst_idle_mem", memory_valid, 0);
    end
    issue(50, 0);
    wait_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
